sqrt_sched: RTL and testbench

Controller and arbiter for the sequential square-root datapath in Project 3. It shares one square-root unit among `NREQ` requesters: it accepts operands through valid/ready ports and picks a requester by round-robin. It then drives the unit's one-cycle `start` and `stop` pulses at the correct cycle offsets and returns each result tagged with the winning requester's index. It sits between the requesting blocks and the square-root datapath, and is the only block that drives that datapath's control inputs.

---
 rtl/sqrt_sched_if.sv | 30 +++
 rtl/sqrt_sched.sv | 105 ++++++++++
 tb/tb_sqrt_sched.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sqrt_sched_if.sv
// sqrt_sched_if: requester, datapath and result signals of the shared square-root scheduler
interface sqrt_sched_if #(
    parameter int NREQ    = 2,
    parameter int NBITSIN = 32,
    parameter int K       = 8
);
    localparam int W  = NBITSIN + K;
    localparam int RW = NBITSIN / 2;
    localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_xin;
    logic [NREQ-1:0]   req_ready;
    logic              dp_start;
    logic              dp_stop;
    logic [W-1:0]      dp_xin;
    logic [RW-1:0]     dp_sqrt;
    logic              res_valid;
    logic              res_ready;
    logic [RW-1:0]     res_sqrt;
    logic [IW-1:0]     res_id;
    logic              busy;
    modport master (
        output req_valid, req_xin, dp_sqrt, res_ready,
        input  req_ready, dp_start, dp_stop, dp_xin, res_valid, res_sqrt, res_id, busy
    );
    modport slave (
        input  req_valid, req_xin, dp_sqrt, res_ready,
        output req_ready, dp_start, dp_stop, dp_xin, res_valid, res_sqrt, res_id, busy
    );
endinterface

// File: rtl/sqrt_sched.sv
// sqrt_sched: round-robin arbiter and start/stop sequencer for one shared square-root datapath
module sqrt_sched #(
    parameter int NREQ    = 2,
    parameter int NBITSIN = 32,
    parameter int K       = 8,
    parameter int NITER   = (NBITSIN + K) / 2
) (
    input logic        clock,
    input logic        reset,
    sqrt_sched_if.slave bus
);
    localparam int W  = NBITSIN + K;
    localparam int RW = NBITSIN / 2;
    localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(NITER + 1);

    typedef enum logic [2:0] {IDLE, START, ITER, STOP, CAPT, HOLD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] last_q, last_d, id_q, id_d, res_id_q, res_id_d;
    logic [W-1:0]  xin_q, xin_d;
    logic [RW-1:0] res_sqrt_q, res_sqrt_d;
    logic [IW-1:0] gnt, idx;
    logic          found;

    // scan upward from the requester after the last winner
    always_comb begin
        gnt = '0;
        idx = '0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IW'((int'(last_q) + i) % NREQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                gnt = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        last_d = last_q;
        id_d = id_q;
        xin_d = xin_q;
        res_sqrt_d = res_sqrt_q;
        res_id_d = res_id_q;
        case (state_q)
            IDLE: if (found) begin
                state_d = START;
                xin_d = bus.req_xin[int'(gnt)*W +: W];
                id_d = gnt;
            end
            START: begin
                cnt_d = '0;
                state_d = ITER;
            end
            ITER: begin
                cnt_d = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(NITER - 1)) ? STOP : ITER;
            end
            STOP: state_d = CAPT;
            CAPT: begin
                res_sqrt_d = bus.dp_sqrt;
                res_id_d = id_q;
                state_d = HOLD;
            end
            HOLD: if (bus.res_ready) begin
                last_d = id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            last_q <= IW'(NREQ - 1);
            id_q <= '0;
            xin_q <= '0;
            res_sqrt_q <= '0;
            res_id_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            last_q <= last_d;
            id_q <= id_d;
            xin_q <= xin_d;
            res_sqrt_q <= res_sqrt_d;
            res_id_q <= res_id_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE && found && !reset) ? {{(NREQ-1){1'b0}}, 1'b1} << gnt : '0;
    assign bus.dp_start  = state_q == START;
    assign bus.dp_stop   = state_q == STOP;
    assign bus.dp_xin    = xin_q;
    assign bus.res_valid = state_q == HOLD;
    assign bus.res_sqrt  = res_sqrt_q;
    assign bus.res_id    = res_id_q;
    assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_sqrt_sched.sv
// tb_sqrt_sched: directed vector table plus multi-cycle sequences for sqrt_sched with a stub datapath
module tb_sqrt_sched;
    localparam int NREQ = 2, NBITSIN = 32, K = 8, NITER = 20;

    typedef struct {
        logic [1:0]  v;
        logic [39:0] x0;
        logic [39:0] x1;
        int          id;
        logic [15:0] es;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    bit both_pulse = 1'b0;
    bit rr_bad = 1'b0;
    vec_t tab[6];

    sqrt_sched_if #(.NREQ(NREQ), .NBITSIN(NBITSIN), .K(K)) bus();
    sqrt_sched #(.NREQ(NREQ), .NBITSIN(NBITSIN), .K(K)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] isqrt(input logic [39:0] x);
        logic [39:0] r, t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (40'd1 << b);
            if (t * t <= x) r = t;
        end
        return r[15:0];
    endfunction

    // stub datapath: garbage while iterating, result valid after the stop pulse
    always @(posedge clock) begin
        if (reset) bus.dp_sqrt <= '0;
        else if (bus.dp_start) bus.dp_sqrt <= 16'hDEAD;
        else if (bus.dp_stop) bus.dp_sqrt <= isqrt(bus.dp_xin);
    end

    always @(negedge clock) begin
        if (bus.dp_start && bus.dp_stop) both_pulse = 1'b1;
        if (!$onehot0(bus.req_ready)) rr_bad = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_ctl"}, {bus.req_ready, bus.dp_start, bus.dp_stop, bus.res_valid, bus.busy}, 0);
        chk({nm, "_dp_xin"}, bus.dp_xin, 0);
        chk({nm, "_res"}, {bus.res_sqrt, bus.res_id}, 0);
    endtask

    task automatic do_op(input logic [15:0] es, input int eid, input logic [39:0] ex,
                         input int hold, input bit keep, output int waited);
        int ts, tp, tv, ns, np;
        bit bad_busy, bad_rr;
        logic [15:0] s0;
        logic [0:0] i0;
        waited = 0;
        #1;
        while (!(|bus.req_ready) && waited < 60) begin
            step();
            waited++;
        end
        chk("grant_seen", |bus.req_ready, 1);
        chk("grant_onehot", bus.req_ready, 64'd1 << eid);
        ts = -1; tp = -1; tv = -1; ns = 0; np = 0; bad_busy = 0; bad_rr = 0;
        for (int t = 1; t <= 40 && tv < 0; t++) begin
            step();
            if (t == 1) begin
                if (!keep) bus.req_valid = '0;
                chk("dp_xin", bus.dp_xin, ex);
            end
            #1;
            if (bus.dp_start) begin ns++; if (ts < 0) ts = t; end
            if (bus.dp_stop) begin np++; if (tp < 0) tp = t; end
            if (bus.res_valid) tv = t;
            if (!bus.busy) bad_busy = 1;
            if (bus.req_ready != 0) bad_rr = 1;
        end
        chk("start_offset", ts, 1);
        chk("stop_offset", tp, NITER + 2);
        chk("valid_offset", tv, NITER + 4);
        chk("pulse_counts", {ns[7:0], np[7:0]}, 16'h0101);
        chk("busy_and_no_ready", {bad_busy, bad_rr}, 0);
        chk("res_sqrt", bus.res_sqrt, es);
        chk("res_id", bus.res_id, eid);
        s0 = bus.res_sqrt;
        i0 = bus.res_id;
        if (hold > 0 && !keep) bus.req_valid = '1;
        for (int h = 0; h < hold; h++) begin
            step();
            chk("backpressure_hold",
                {bus.res_valid, bus.busy, bus.res_sqrt, bus.res_id, bus.req_ready, bus.dp_start},
                {2'b11, s0, i0, 2'b00, 1'b0});
        end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        if (!keep) bus.req_valid = '0;
        #1;
        chk("post_handshake_idle", {bus.busy, bus.res_valid}, 0);
    endtask

    initial begin
        int w, l, g, ns, np, nv;
        logic [1:0] v;
        logic [39:0] x0, x1;
        tab[0] = '{2'b11, 40'd49,         40'd25,      0, 16'd7};
        tab[1] = '{2'b11, 40'd81,         40'd2,       1, 16'd1};
        tab[2] = '{2'b01, 40'd6,          40'd0,       0, 16'd2};
        tab[3] = '{2'b01, 40'hFFFF_FFFF,  40'd0,       0, 16'd65535};
        tab[4] = '{2'b10, 40'd0,          40'd1000000, 1, 16'd1000};
        tab[5] = '{2'b11, 40'd3,          40'd48,      0, 16'd1};
        bus.req_valid = '0;
        bus.req_xin = '0;
        bus.res_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        chk_reset_vals("reset");

        for (int i = 0; i < 6; i++) begin
            bus.req_valid = tab[i].v;
            bus.req_xin = {tab[i].x1, tab[i].x0};
            do_op(tab[i].es, tab[i].id, tab[i].id == 1 ? tab[i].x1 : tab[i].x0, 0, 1'b0, w);
        end

        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_xin = {40'd36, 40'd16};
        for (int i = 0; i < 4; i++) begin
            do_op(i % 2 == 1 ? 16'd6 : 16'd4, i % 2, i % 2 == 1 ? 40'd36 : 40'd16, 0, 1'b1, w);
            if (i > 0) chk("back_to_back_wait", w, 0);
        end
        bus.req_valid = '0;

        bus.req_valid = 2'b01;
        bus.req_xin = {40'd0, 40'd400};
        do_op(16'd20, 0, 40'd400, 10, 1'b0, w);

        bus.req_valid = 2'b01;
        bus.req_xin = {40'd0, 40'd10000};
        #1;
        chk("abort_grant", bus.req_ready, 2'b01);
        for (int i = 0; i < 10; i++) begin
            step();
            bus.req_valid = '0;
        end
        chk("abort_in_iter", {bus.busy, bus.dp_start, bus.dp_stop}, 3'b100);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_vals("midreset");
        ns = 0; np = 0; nv = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.dp_start) ns++;
            if (bus.dp_stop) np++;
            if (bus.res_valid) nv++;
        end
        chk("abort_silent", {ns[7:0], np[7:0], nv[7:0]}, 0);
        bus.req_valid = 2'b11;
        bus.req_xin = {40'd9, 40'd64};
        do_op(16'd8, 0, 40'd64, 0, 1'b0, w);

        l = 0;
        for (int n = 0; n < 100; n++) begin
            v = 2'($urandom_range(1, 3));
            x0 = {8'd0, 32'($urandom)};
            x1 = {8'd0, 32'($urandom)};
            g = (l + 1) % 2;
            if (!v[g]) g = l;
            bus.req_valid = v;
            bus.req_xin = {x1, x0};
            do_op(isqrt(g == 1 ? x1 : x0), g, g == 1 ? x1 : x0, $urandom_range(0, 2), 1'b0, w);
            l = g;
        end

        chk("start_stop_overlap", both_pulse, 0);
        chk("ready_not_onehot", rr_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
